// File: rtl/hier_status_collector_pkg.sv
// Shared types and helpers for the hierarchical status collector.
// Imported by the interface, the arbiter and the top.
package hier_collect_pkg;

  localparam int ACCEPT_CNT_W = 16;

  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hier_status_collector_if.sv
// Child-side and parent-side valid/ready channels of the collector.
// The collector uses the slave view; the producer/consumer side uses master.
interface hier_status_collector_if
  import hier_collect_pkg::*;
#(
  parameter int N_CHILD = 5,
  parameter int DATA_W  = 16
);
  localparam int ID_W = id_width(N_CHILD);

  logic [N_CHILD-1:0]        child_valid;
  logic [N_CHILD*DATA_W-1:0] child_data;
  logic [N_CHILD-1:0]        child_ready;
  logic                      up_valid;
  logic [ID_W+DATA_W-1:0]    up_data;
  logic                      up_ready;

  modport master (
    output child_valid, child_data, up_ready,
    input  child_ready, up_valid, up_data
  );

  modport slave (
    input  child_valid, child_data, up_ready,
    output child_ready, up_valid, up_data
  );

endinterface

// File: rtl/hier_status_collector_arb.sv
// Round-robin arbiter; search starts one past the last completed grant.
// The pointer moves only when the granted transfer completes.
module hier_rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          enable,
  input  logic          done,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) ptr <= IW'(N - 1);
    else if (done) ptr <= grant_idx;
  end

  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && enable && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/hier_status_collector.sv
// Arbitrates child status words into a small FIFO tagged with the
// child index, and forwards the head to the parent level.
module hier_status_collector
  import hier_collect_pkg::*;
#(
  parameter int N_CHILD    = 5,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  hier_status_collector_if.slave  bus,
  output logic [ACCEPT_CNT_W-1:0] accept_cnt
);

  localparam int ID_W = id_width(N_CHILD);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] payload;
  } entry_t;

  entry_t           mem [FIFO_DEPTH];
  entry_t           wr_entry;
  entry_t           last_q;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             arb_en;
  logic             push;
  logic             pop;
  logic [N_CHILD-1:0] grant;
  logic [ID_W-1:0]  grant_idx;

  // Full blocks grants even when a pop happens in the same cycle.
  assign full   = (count == CW'(FIFO_DEPTH));
  assign arb_en = !rst && !flush && !full;

  hier_rr_arbiter #(
    .N  (N_CHILD),
    .IW (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.child_valid),
    .enable    (arb_en),
    .done      (push),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign push            = |grant;
  assign bus.child_ready = grant;
  assign bus.up_valid    = (count != '0);
  assign pop = bus.up_valid && bus.up_ready && !flush;

  always_comb begin
    wr_entry.id      = grant_idx;
    wr_entry.payload =
      bus.child_data[int'(grant_idx)*DATA_W +: DATA_W];
  end

  // While empty, keep showing the last head rather than a stale slot.
  assign bus.up_data = bus.up_valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_q     <= '0;
      accept_cnt <= '0;
    end else begin
      if (bus.up_valid) last_q <= mem[rd_ptr];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr     <= wr_ptr + 1'b1;
          accept_cnt <= accept_cnt + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hier_status_collector.sv
// Directed and random checks of the collector against a queue model.
// Expectations come from round-robin rules over a word queue.
module tb_hier_status_collector;

  localparam int N     = 5;
  localparam int DW    = 16;
  localparam int IW    = 3;
  localparam int DEPTH = 4;
  localparam int EW    = IW + DW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] accept_cnt;

  always #5 clk = ~clk;

  hier_status_collector_if #(.N_CHILD(N), .DATA_W(DW)) bus ();

  hier_status_collector #(
    .N_CHILD    (N),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .accept_cnt (accept_cnt)
  );

  logic [EW-1:0] q[$];
  logic [EW-1:0] last_head = '0;
  int lg = N - 1;
  int acc = 0;
  int passed = 0;
  int total = 0;
  int gcnt[N];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pick();
    int idx;
    if (rst || flush || q.size() >= DEPTH) return -1;
    for (int k = 1; k <= N; k++) begin
      idx = (lg + k) % N;
      if (bus.child_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic step(bit en);
    int g;
    logic [EW-1:0] w;
    logic [EW-1:0] exp_data;
    @(negedge clk);
    g = pick();
    w = '0;
    if (g >= 0) w = {IW'(g), bus.child_data[g*DW +: DW]};
    exp_data = (q.size() != 0) ? q[0] : last_head;
    if (en) begin
      chk("child_ready", 32'(bus.child_ready),
          (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("up_valid", 32'(bus.up_valid), 32'(q.size() != 0));
      chk("up_data", 32'(bus.up_data), 32'(exp_data));
      chk("accept_cnt", 32'(accept_cnt), 32'(acc[15:0]));
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      lg = N - 1;
      acc = 0;
      last_head = '0;
    end else begin
      if (q.size() != 0) last_head = q[0];
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && bus.up_ready) void'(q.pop_front());
        if (g >= 0) begin
          q.push_back(w);
          lg = g;
          acc++;
          gcnt[g]++;
        end
      end
    end
    #1;
  endtask

  task automatic pattern();
    for (int i = 0; i < N; i++)
      bus.child_data[i*DW +: DW] = 16'(16'h1000 * i + 16'h0055 + acc);
  endtask

  initial begin
    logic [EW-1:0] frozen;
    logic [15:0]   a0;
    bus.child_valid = '0;
    bus.child_data  = '0;
    bus.up_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(1);
    chk("rst_up_data", 32'(bus.up_data), 32'd0);
    chk("rst_cnt", 32'(accept_cnt), 32'd0);
    rst = 1'b0;

    bus.child_data[2*DW +: DW] = 16'h00AB;
    bus.child_valid = 5'b00100;
    bus.up_ready = 1'b1;
    #1;
    chk("single_ready", 32'(bus.child_ready), 32'b00100);
    step(1);
    chk("single_data", 32'(bus.up_data), 32'({3'd2, 16'h00AB}));
    chk("single_valid", 32'(bus.up_valid), 32'd1);
    chk("single_cnt", 32'(accept_cnt), 32'd1);
    bus.child_valid = '0;
    step(1);

    for (int i = 0; i < N; i++) gcnt[i] = 0;
    bus.child_valid = '1;
    repeat (10) begin
      pattern();
      step(1);
    end
    for (int i = 0; i < N; i++)
      chk("fair_cnt", 32'(gcnt[i]), 32'd2);

    bus.up_ready = 1'b0;
    repeat (6) begin
      pattern();
      step(1);
    end
    chk("bp_ready", 32'(bus.child_ready), 32'd0);
    frozen = bus.up_data;
    repeat (2) step(1);
    chk("bp_frozen", 32'(bus.up_data), 32'(frozen));
    bus.child_valid = '0;
    bus.up_ready = 1'b1;
    repeat (4) step(1);
    chk("bp_drained", 32'(bus.up_valid), 32'd0);

    bus.child_valid = '1;
    bus.up_ready = 1'b0;
    repeat (5) begin
      pattern();
      step(1);
    end
    bus.up_ready = 1'b1;
    #1;
    chk("full_pop_ready", 32'(bus.child_ready), 32'd0);
    step(1);
    bus.up_ready = 1'b0;
    #1;
    chk("full_regrant", 32'($countones(bus.child_ready)), 32'd1);
    step(1);
    bus.child_valid = '0;
    bus.up_ready = 1'b1;
    repeat (5) step(1);

    bus.child_valid = '1;
    bus.up_ready = 1'b0;
    repeat (3) begin
      pattern();
      step(1);
    end
    bus.child_valid = 5'b00010;
    flush = 1'b1;
    #1;
    chk("flush_ready", 32'(bus.child_ready), 32'd0);
    a0 = accept_cnt;
    step(1);
    flush = 1'b0;
    bus.child_valid = '0;
    #1;
    chk("flush_valid", 32'(bus.up_valid), 32'd0);
    chk("flush_cnt", 32'(accept_cnt), 32'(a0));
    step(1);

    repeat (400) begin
      bus.child_valid = N'($urandom_range(0, 31));
      bus.child_data  = 80'({$urandom, $urandom, $urandom});
      bus.up_ready    = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 15) == 0);
      step(1);
    end
    flush = 1'b0;

    bus.child_valid = '1;
    bus.up_ready = 1'b1;
    while (acc < 65533) step(0);
    repeat (6) step(1);
    chk("wrap_cnt", 32'(accept_cnt), 32'(acc - 65536));

    bus.up_ready = 1'b0;
    repeat (5) step(1);
    rst = 1'b1;
    #1;
    chk("rst_full_ready", 32'(bus.child_ready), 32'd0);
    step(1);
    chk("rst_full_valid", 32'(bus.up_valid), 32'd0);
    chk("rst_full_data", 32'(bus.up_data), 32'd0);
    chk("rst_full_cnt", 32'(accept_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_regrant", 32'(bus.child_ready), 32'b00001);
    step(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
